// File: rtl/eq_seq_if.sv
// eq_seq_if
// Purpose : groups the request/result handshake of eq_seq_ctrl together with
//           the slice bus that drives the shared 2-bit equality comparator.
// Signals :
//   start          request from the sequencing FSM
//   a, b           W-bit operands, latched by the controller on an accepted start
//   ready          controller is idle and will accept start
//   done           one-cycle pulse, result valid
//   aeqb           comparison result (1 = equal), held until next accepted start
//   mism_idx       index of the first mismatching slice (0 when equal)
//   cmp_a, cmp_b   current 2-bit slice presented to the comparator
//   cmp_eq         comparator result for the presented slice (same cycle)
// Modports:
//   slave   the controller side (eq_seq_ctrl)
//   master  the environment side (requester plus comparator)
interface eq_seq_if #(
  parameter int W  = 8,
  parameter int IW = 2
);
  logic          start;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          ready;
  logic          done;
  logic          aeqb;
  logic [IW-1:0] mism_idx;
  logic [1:0]    cmp_a;
  logic [1:0]    cmp_b;
  logic          cmp_eq;

  modport slave (
    input  start, a, b, cmp_eq,
    output ready, done, aeqb, mism_idx, cmp_a, cmp_b
  );

  modport master (
    output start, a, b, cmp_eq,
    input  ready, done, aeqb, mism_idx, cmp_a, cmp_b
  );
endinterface

// File: rtl/eq_seq_ctrl.sv
// eq_seq_ctrl
// Purpose : compares two W-bit words for equality by walking them through a
//           single shared 2-bit equality comparator, LSB slice first, one
//           slice per cycle. Stops on the first mismatching slice and reports
//           the result with a one-cycle done pulse.
// Ports   :
//   clk    system clock, all state updates on the rising edge
//   reset  synchronous, active-high reset
//   bus    eq_seq_if.slave: start/a/b request, ready/done/aeqb/mism_idx
//          result, cmp_a/cmp_b/cmp_eq comparator slice bus
// Parameters:
//   W   operand width, even and >= 2 (N = W/2 slices)
//   IW  slice index width, 2**IW >= N
module eq_seq_ctrl #(
  parameter int W  = 8,
  parameter int IW = 2
) (
  input  logic   clk,
  input  logic   reset,
  eq_seq_if.slave bus
);

  localparam int            N    = W / 2;
  localparam logic [IW-1:0] LAST = IW'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state;
  state_t        state_nx;
  logic [W-1:0]  a_reg;
  logic [W-1:0]  b_reg;
  logic [IW-1:0] idx;
  logic          aeqb_q;
  logic [IW-1:0] mism_q;
  logic [1:0]    slice_a;
  logic [1:0]    slice_b;

  // State register. The controller only ever moves IDLE -> CMP -> DONE -> IDLE,
  // so a reset anywhere simply returns it to IDLE without a done pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic. CMP finishes either on the first mismatching slice or
  // after the last slice has matched; idx is never advanced past LAST, so
  // there is no wrap-around to worry about.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (bus.start) state_nx = CMP;
      CMP:     if (!bus.cmp_eq || (idx == LAST)) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Operand latches, slice index and the held result. Operands are captured
  // only on an accepted start so later changes on a/b cannot disturb a
  // comparison in flight. The result is cleared on acceptance and then
  // written once, at the cycle the comparison finishes.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_reg  <= '0;
      b_reg  <= '0;
      idx    <= '0;
      aeqb_q <= 1'b0;
      mism_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            a_reg  <= bus.a;
            b_reg  <= bus.b;
            idx    <= '0;
            aeqb_q <= 1'b0;
            mism_q <= '0;
          end
        end
        CMP: begin
          if (!bus.cmp_eq) begin
            aeqb_q <= 1'b0;
            mism_q <= idx;
          end else if (idx == LAST) begin
            aeqb_q <= 1'b1;
            mism_q <= '0;
          end else begin
            idx <= idx + IW'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Slice selection: an explicit mux over the N slices keeps the index
  // arithmetic constant per branch and never reads beyond the operand.
  always_comb begin
    slice_a = 2'b00;
    slice_b = 2'b00;
    for (int i = 0; i < N; i++) begin
      if (idx == IW'(i)) begin
        slice_a = a_reg[2*i +: 2];
        slice_b = b_reg[2*i +: 2];
      end
    end
  end

  // Outputs are decoded from registered state only; the comparator bus is
  // forced to zero outside CMP so the shared comparator sees quiet inputs.
  assign bus.ready    = (state == IDLE);
  assign bus.done     = (state == DONE);
  assign bus.aeqb     = aeqb_q;
  assign bus.mism_idx = mism_q;
  assign bus.cmp_a    = (state == CMP) ? slice_a : 2'b00;
  assign bus.cmp_b    = (state == CMP) ? slice_b : 2'b00;

endmodule

// File: tb/tb_eq_seq_ctrl.sv
// tb_eq_seq_ctrl
// Purpose : self-checking bench for eq_seq_ctrl. Drives requests, pushes the
//           expected result and completion edge into a scoreboard queue when a
//           request is issued, and pops/compares when done appears. Also
//           covers a W=2 build through a second instance.
// Ports   : none (top-level bench).
module tb_eq_seq_ctrl;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  eq_seq_if #(.W(8), .IW(2)) bus8 ();
  eq_seq_if #(.W(2), .IW(1)) bus2 ();

  // Behavioural stand-in for the 2-bit equality comparator on each build.
  assign bus8.cmp_eq = (bus8.cmp_a == bus8.cmp_b);
  assign bus2.cmp_eq = (bus2.cmp_a == bus2.cmp_b);

  eq_seq_ctrl #(.W(8), .IW(2)) dut8 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus8)
  );

  eq_seq_ctrl #(.W(2), .IW(1)) dut2 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus2)
  );

  typedef struct {
    logic eq;
    int   mism;
    int   due;
  } exp_t;

  exp_t sb[$];
  int   edge_cnt = 0;
  int   errors   = 0;
  int   checks   = 0;

  // Rising-edge counter used to timestamp request acceptance and done.
  always @(posedge clk) edge_cnt++;

  // Reference model: first mismatching slice from the LSB end decides the
  // result; done appears n edges after acceptance for a full match and k+1
  // edges after acceptance for a mismatch at slice k.
  function automatic exp_t model(input logic [7:0] x, input logic [7:0] y,
                                 input int n, input int edge0);
    exp_t e;
    e.eq   = 1'b1;
    e.mism = 0;
    e.due  = edge0 + n;
    for (int i = n - 1; i >= 0; i--) begin
      if (x[2*i +: 2] != y[2*i +: 2]) begin
        e.eq   = 1'b0;
        e.mism = i;
        e.due  = edge0 + i + 1;
      end
    end
    return e;
  endfunction

  // Issue a one-cycle start on the W=8 instance; returns at cycle 1.
  task automatic issue8(input logic [7:0] x, input logic [7:0] y);
    bus8.a     = x;
    bus8.b     = y;
    bus8.start = 1'b1;
    sb.push_back(model(x, y, 4, edge_cnt + 1));
    @(posedge clk);
    @(negedge clk);
    bus8.start = 1'b0;
  endtask

  // Wait (bounded) for done on the selected instance, then pop the
  // scoreboard and compare result, index and completion edge.
  task automatic wait_done(input bit sel2, input string name);
    exp_t e;
    bit   seen = 1'b0;
    logic d;
    for (int n = 0; n < 40; n++) begin
      d = sel2 ? bus2.done : bus8.done;
      if (d === 1'b1) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("[TB] FAIL %s_timeout: done not seen in 40 cycles, required a done pulse", name);
      if (sb.size() > 0) void'(sb.pop_front());
    end else if (sb.size() == 0) begin
      errors++;
      $display("[TB] FAIL %s_unexpected: done at edge %0d, required no done", name, edge_cnt);
    end else begin
      e = sb.pop_front();
      if (edge_cnt !== e.due) begin
        errors++;
        $display("[TB] FAIL %s_latency: done at edge %0d, required edge %0d", name, edge_cnt, e.due);
      end
      checks++;
      if ((sel2 ? bus2.aeqb : bus8.aeqb) !== e.eq) begin
        errors++;
        $display("[TB] FAIL %s_aeqb: got %b, required %b", name,
                 sel2 ? bus2.aeqb : bus8.aeqb, e.eq);
      end
      checks++;
      if ((sel2 ? int'(bus2.mism_idx) : int'(bus8.mism_idx)) !== e.mism) begin
        errors++;
        $display("[TB] FAIL %s_mism_idx: got %0d, required %0d", name,
                 sel2 ? int'(bus2.mism_idx) : int'(bus8.mism_idx), e.mism);
      end
      checks++;
      if ((sel2 ? {bus2.ready, bus2.cmp_a} : {bus8.ready, bus8.cmp_a}) !== 3'b000) begin
        errors++;
        $display("[TB] FAIL %s_done_state: ready/cmp_a got %b, required 000", name,
                 sel2 ? {bus2.ready, bus2.cmp_a} : {bus8.ready, bus8.cmp_a});
      end
    end
  endtask

  // One cycle after done: done must have dropped and ready returned.
  task automatic check_pulse_end(input string name);
    @(negedge clk);
    checks++;
    if ({bus8.done, bus8.ready} !== 2'b01) begin
      errors++;
      $display("[TB] FAIL %s_pulse_end: done/ready got %b, required 01", name, {bus8.done, bus8.ready});
    end
  endtask

  // Compare all observable outputs of the W=8 instance with reset values.
  task automatic check_reset_vals(input string name);
    checks++;
    if ({bus8.ready, bus8.done, bus8.aeqb, bus8.mism_idx, bus8.cmp_a, bus8.cmp_b} !== 9'b1_0_0_00_00_00) begin
      errors++;
      $display("[TB] FAIL %s: ready,done,aeqb,mism,cmp_a,cmp_b got %b, required 100000000", name,
               {bus8.ready, bus8.done, bus8.aeqb, bus8.mism_idx, bus8.cmp_a, bus8.cmp_b});
    end
    checks++;
    if ({bus2.ready, bus2.done, bus2.aeqb} !== 3'b100) begin
      errors++;
      $display("[TB] FAIL %s_w2: ready,done,aeqb got %b, required 100", name,
               {bus2.ready, bus2.done, bus2.aeqb});
    end
  endtask

  task automatic test_reset();
    reset      = 1'b1;
    bus8.start = 1'b0;
    bus8.a     = '0;
    bus8.b     = '0;
    bus2.start = 1'b0;
    bus2.a     = '0;
    bus2.b     = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_vals("reset_initial");
    reset = 1'b0;
  endtask

  task automatic test_reset_mid_cmp();
    bit saw_done = 1'b0;
    issue8(8'hA5, 8'hA5);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    check_reset_vals("reset_mid_cmp");
    sb.delete();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus8.done === 1'b1) saw_done = 1'b1;
    end
    checks++;
    if (saw_done) begin
      errors++;
      $display("[TB] FAIL reset_abort: done pulse got 1, required 0 after aborted compare");
    end
  endtask

  task automatic test_full_match();
    logic [7:0] x = 8'hA5;
    issue8(x, x);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({bus8.cmp_a, bus8.cmp_b} !== {x[2*i +: 2], x[2*i +: 2]}) begin
        errors++;
        $display("[TB] FAIL full_match_slice%0d: cmp_a/cmp_b got %b, required %b", i,
                 {bus8.cmp_a, bus8.cmp_b}, {x[2*i +: 2], x[2*i +: 2]});
      end
      @(negedge clk);
    end
    wait_done(1'b0, "full_match");
    check_pulse_end("full_match");
  endtask

  task automatic test_early_mismatch();
    issue8(8'h00, 8'h04);
    wait_done(1'b0, "early_mismatch");
    check_pulse_end("early_mismatch");
  endtask

  task automatic test_msb_mismatch();
    issue8(8'h3F, 8'hFF);
    wait_done(1'b0, "msb_mismatch");
    check_pulse_end("msb_mismatch");
  endtask

  task automatic test_ignored_start();
    issue8(8'h3C, 8'h3C);
    bus8.a     = 8'hFF;
    bus8.b     = 8'h00;
    bus8.start = 1'b1;
    @(negedge clk);
    bus8.start = 1'b0;
    wait_done(1'b0, "ignored_start");
    check_pulse_end("ignored_start");
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if ({bus8.done, bus8.aeqb} !== 2'b01) begin
        errors++;
        $display("[TB] FAIL ignored_start_hold%0d: done/aeqb got %b, required 01", i,
                 {bus8.done, bus8.aeqb});
      end
    end
    issue8(8'h00, 8'h04);
    checks++;
    if (bus8.aeqb !== 1'b0) begin
      errors++;
      $display("[TB] FAIL accept_clears_aeqb: got %b, required 0", bus8.aeqb);
    end
    wait_done(1'b0, "after_ignored");
    check_pulse_end("after_ignored");
  endtask

  task automatic test_back_to_back();
    bus8.a     = 8'h5A;
    bus8.b     = 8'h5A;
    bus8.start = 1'b1;
    sb.push_back(model(8'h5A, 8'h5A, 4, edge_cnt + 1));
    @(negedge clk);
    wait_done(1'b0, "b2b_first");
    bus8.b = 8'h5B;
    sb.push_back(model(8'h5A, 8'h5B, 4, edge_cnt + 2));
    @(negedge clk);
    wait_done(1'b0, "b2b_second");
    bus8.start = 1'b0;
    check_pulse_end("b2b_second");
  endtask

  task automatic test_w2();
    logic [1:0] xa [2] = '{2'b11, 2'b10};
    logic [1:0] xb [2] = '{2'b11, 2'b11};
    for (int t = 0; t < 2; t++) begin
      bus2.a     = xa[t];
      bus2.b     = xb[t];
      bus2.start = 1'b1;
      sb.push_back(model({6'b0, xa[t]}, {6'b0, xb[t]}, 1, edge_cnt + 1));
      @(posedge clk);
      @(negedge clk);
      bus2.start = 1'b0;
      checks++;
      if (bus2.cmp_a !== xa[t]) begin
        errors++;
        $display("[TB] FAIL w2_cmp_a%0d: got %b, required %b", t, bus2.cmp_a, xa[t]);
      end
      @(negedge clk);
      wait_done(1'b1, "w2");
      @(negedge clk);
    end
  endtask

  initial begin
    $display("[TB] starting eq_seq_ctrl bench");
    test_reset();
    @(negedge clk);
    test_full_match();
    test_early_mismatch();
    test_msb_mismatch();
    test_ignored_start();
    test_back_to_back();
    test_reset_mid_cmp();
    test_w2();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
